spi_reg_peripheral: RTL and testbench
=====================================

Name: spi_reg_peripheral

Overview:
- SPI target (mode 0, write-centric) that sits directly upstream of the PWM peripheral and owns its five 8-bit control registers.
- Receives 16-bit frames from an external controller on three chip input pins, synchronised into the system clock domain.
- Commits a write to the addressed register only when the frame is complete and valid.
- Register outputs feed the PWM peripheral's output-enable, PWM-enable and duty-cycle inputs directly.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk, copi and ncs (minimum 2).
- MAX_ADDR, 4, highest valid register address; frames addressed above it are discarded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock from controller, asynchronous to clk
- copi  input  1  SPI controller-out/target-in data, asynchronous
- ncs  input  1  SPI chip select, active low, asynchronous
- cipo  output  1  SPI target-out data (active only with the optional feature)
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04

Behaviour:
- Reset (rst_n low, asynchronous):
  - All five registers = 0x00; cipo = 0; synchronisers, shift register and bit counter cleared.
  - Reset mid-frame aborts the frame with no register change.
- Synchronisation:
  - sclk, copi and ncs each pass through SYNC_STAGES flops.
  - One further flop on sclk_s and ncs_s provides edge detection.
  - Edge definitions: sclk_rise = sclk_s & ~sclk_d; ncs_fall and ncs_rise defined likewise.
- Frame format, MSB first:
  - bit15 = R/W (1 = write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- States:
  - IDLE (ncs_s high): sclk edges ignored, counter held.
  - ncs_fall -> RECV: 16-bit shift register and 5-bit bit counter cleared.
  - RECV: on each sclk_rise with ncs_s low, shift copi_s into the LSB. Counter increments and saturates at 16; bits after the 16th are ignored and the shift register is frozen.
  - ncs_rise -> COMMIT (one cycle) -> IDLE.
- COMMIT writes data to the register at the address only if all hold:
  - counter == 16
  - bit15 == 1
  - address <= MAX_ADDR
  - Otherwise the frame is silently discarded.
- Atomicity: registers change only in COMMIT, never mid-frame.
- Latency: register output updates on the clk edge following ncs_rise detection, i.e. at most SYNC_STAGES+2 clk cycles after the ncs pin rises.
- Simultaneous sclk_rise and ncs_rise in the same cycle: the sclk edge is accepted only if ncs_s is low in that cycle; otherwise it is dropped.
- ncs_fall while already in RECV is impossible by edge definition. A glitch on ncs (rise then fall) ends the frame and starts a new one.
- Timing requirement: sclk high and low phases are each ≥ SYNC_STAGES+1 clk periods. Recommended sclk ≤ clk/10.
- Registers hold their value indefinitely between writes. Reads never modify them.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - A frame with bit15 == 0 is a read.
  - On the 8th sclk_rise, the addressed register is loaded into an 8-bit tx shift register; address > MAX_ADDR loads 0x00.
  - cipo presents tx[7] after the next synchronised sclk fall, then shifts on each subsequent sclk fall for the remaining 7 bits.
  - cipo = 0 while ncs_s is high and during the R/W and address phases.
  - Read frames never commit.
- Undefined: cipo tied 0; read frames are discarded as invalid writes.

Test Plan:
- Reset, then write frame 0x80FF (write, addr 0x00, data 0xFF) -> en_reg_out_7_0 = 0xFF within SYNC_STAGES+2 clk of ncs rise; all other registers remain 0x00.
- Write 0x8480 (addr 0x04, data 0x80), then 0x8255 (addr 0x02, data 0x55) -> pwm_duty_cycle = 0x80, en_reg_pwm_7_0 = 0x55; neither changes before its ncs rise.
- Write 0x85AA (addr 0x05) and 0x0411 (read bit, feature off) -> all registers unchanged.
- Frame of only 15 bits, then a frame of 17 bits (0x83C3 followed by an extra 1) -> 15-bit frame discarded; 17-bit frame commits en_reg_pwm_15_8 = 0xC3.
- Assert rst_n low after 10 bits of 0x81F0, then complete the frame with reset released -> en_reg_out_15_8 stays 0x00. A following full 0x81F0 frame -> 0x0F... correction: sets en_reg_out_15_8 = 0xF0.
- With SPI_READBACK_EN: write 0x8433, then read frame 0x0400 -> cipo shifts out 0x33 MSB-first during sclk 9–16; a read of addr 0x06 returns 0x00.

Source files
------------

// File: rtl/spi_reg_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_peripheral
// Brief    : Mode-0 SPI target owning the five 8-bit PWM control registers.
//            Optional readback on cipo is enabled by defining SPI_READBACK_EN.
// Revision : 1.0
// ============================================================================
module spi_reg_peripheral #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   localparam logic [4:0] c_FRAME_BITS = 5'd16;
   localparam logic [6:0] c_MAX_ADDR   = 7'(MAX_ADDR);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
   logic                   r_sclk_d, r_ncs_d;
   logic [15:0]            r_shift;
   logic [4:0]             r_bit_cnt;
   logic [7:0]             r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;

   logic w_sclk_s, w_copi_s, w_ncs_s;
   logic w_sclk_rise, w_ncs_fall, w_ncs_rise;
   logic w_shift_en, w_commit;
   logic [6:0] w_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '0;
         r_sclk_d    <= 1'b0;
         r_ncs_d     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
         r_sclk_d    <= w_sclk_s;
         r_ncs_d     <= w_ncs_s;
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
   assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
   assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // A fall seen during COMMIT is an ncs glitch: it opens the next frame.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_ncs_fall) w_state_nxt = S_RECV;
         S_RECV:   if (w_ncs_rise) w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = w_ncs_fall ? S_RECV : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Bits beyond the 16th are dropped once the counter saturates.
   assign w_shift_en = (r_state == S_RECV) & w_sclk_rise & ~w_ncs_s &
                       (r_bit_cnt != c_FRAME_BITS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_ncs_fall) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_shift_en) begin
         r_shift   <= {r_shift[14:0], w_copi_s};
         r_bit_cnt <= r_bit_cnt + 5'd1;
      end
   end

   assign w_addr   = r_shift[14:8];
   assign w_commit = (r_state == S_COMMIT) & (r_bit_cnt == c_FRAME_BITS) &
                     r_shift[15] & (w_addr <= c_MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg0 <= '0;
         r_reg1 <= '0;
         r_reg2 <= '0;
         r_reg3 <= '0;
         r_reg4 <= '0;
      end else if (w_commit) begin
         case (w_addr)
            7'd0:    r_reg0 <= r_shift[7:0];
            7'd1:    r_reg1 <= r_shift[7:0];
            7'd2:    r_reg2 <= r_shift[7:0];
            7'd3:    r_reg3 <= r_shift[7:0];
            7'd4:    r_reg4 <= r_shift[7:0];
            default: ;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_reg0;
   assign en_reg_out_15_8 = r_reg1;
   assign en_reg_pwm_7_0  = r_reg2;
   assign en_reg_pwm_15_8 = r_reg3;
   assign pwm_duty_cycle  = r_reg4;

`ifdef SPI_READBACK_EN
   logic       w_sclk_fall, w_rd_load;
   logic [6:0] w_rd_addr;
   logic [7:0] w_rd_data;
   logic [7:0] r_tx;
   logic       r_cipo;

   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   // Eighth accepted bit completes the address of a read (bit15 == 0) frame.
   assign w_rd_load   = w_shift_en & (r_bit_cnt == 5'd7) & ~r_shift[6];
   assign w_rd_addr   = {r_shift[5:0], w_copi_s};

   always_comb begin
      w_rd_data = 8'h00;
      if (w_rd_addr <= c_MAX_ADDR) begin
         case (w_rd_addr)
            7'd0:    w_rd_data = r_reg0;
            7'd1:    w_rd_data = r_reg1;
            7'd2:    w_rd_data = r_reg2;
            7'd3:    w_rd_data = r_reg3;
            7'd4:    w_rd_data = r_reg4;
            default: w_rd_data = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx   <= '0;
         r_cipo <= 1'b0;
      end else if (w_ncs_fall) begin
         r_tx   <= '0;
         r_cipo <= 1'b0;
      end else if (w_rd_load) begin
         r_tx <= w_rd_data;
      end else if (w_sclk_fall & ~w_ncs_s & (r_state == S_RECV)) begin
         r_cipo <= r_tx[7];
         r_tx   <= {r_tx[6:0], 1'b0};
      end
   end

   assign cipo = r_cipo & ~w_ncs_s;
`else
   assign cipo = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_peripheral
// Brief    : Directed self-checking bench for spi_reg_peripheral.
// Revision : 1.0
// ============================================================================
module tb_spi_reg_peripheral;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 50;

   logic       clk = 1'b0;
   logic       rst_n, sclk, copi, ncs;
   logic       cipo;
   logic [7:0] r0, r1, r2, r3, r4;
   logic [15:0] rx_word;
   int         n_cmp = 0;
   int         n_err = 0;

   spi_reg_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(4)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .cipo            (cipo),
      .en_reg_out_7_0  (r0),
      .en_reg_out_15_8 (r1),
      .en_reg_pwm_7_0  (r2),
      .en_reg_pwm_15_8 (r3),
      .pwm_duty_cycle  (r4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [39:0] exp);
      check({tag, ".reg0"}, {24'd0, r0}, {24'd0, exp[39:32]});
      check({tag, ".reg1"}, {24'd0, r1}, {24'd0, exp[31:24]});
      check({tag, ".reg2"}, {24'd0, r2}, {24'd0, exp[23:16]});
      check({tag, ".reg3"}, {24'd0, r3}, {24'd0, exp[15:8]});
      check({tag, ".reg4"}, {24'd0, r4}, {24'd0, exp[7:0]});
   endtask

   task automatic frame_start();
      ncs = 1'b0;
      #(HALF);
   endtask

   // Sends n bits of word MSB first; cipo captured just before each rise.
   task automatic spi_bits(input logic [31:0] word, input int n);
      for (int i = 0; i < n; i++) begin
         copi = word[n-1-i];
         #(HALF);
         if (i < 16) rx_word[15-i] = cipo;
         sclk = 1'b1;
         #(HALF);
         sclk = 1'b0;
      end
      #(HALF);
   endtask

   task automatic frame_end();
      ncs = 1'b1;
      repeat (SYNC_STAGES + 2) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [31:0] word, input int n);
      frame_start();
      spi_bits(word, n);
      frame_end();
      #(HALF*2);
   endtask

   initial begin
      rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; rx_word = '0;
      #100;
      check_all("reset", 40'h00_00_00_00_00);
      check("reset.cipo", {31'd0, cipo}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      #200;

      frame(32'h80FF, 16);
      check_all("wr0", 40'hFF_00_00_00_00);

      frame_start(); spi_bits(32'h8480, 16);
      check("pre_wr4", {24'd0, r4}, 32'h00);
      frame_end();
      check("wr4", {24'd0, r4}, 32'h80);
      #(HALF*2);
      frame_start(); spi_bits(32'h8255, 16);
      check("pre_wr2", {24'd0, r2}, 32'h00);
      frame_end();
      check("wr2", {24'd0, r2}, 32'h55);
      #(HALF*2);

      frame(32'h85AA, 16);
      frame(32'h0411, 16);
      check_all("badaddr_read", 40'hFF_00_55_00_80);

      frame(32'h83C3 >> 1, 15);
      check("short15", {24'd0, r3}, 32'h00);
      frame({15'd0, 16'h83C3, 1'b1}, 17);
      check("long17", {24'd0, r3}, 32'hC3);

      frame_start(); spi_bits(32'h81F0 >> 6, 10);
      rst_n = 1'b0;
      #(HALF*2);
      @(negedge clk); rst_n = 1'b1;
      spi_bits(32'h81F0 & 32'h3F, 6);
      frame_end();
      #(HALF*2);
      check_all("midreset", 40'h00_00_00_00_00);
      frame(32'h81F0, 16);
      check("wr1", {24'd0, r1}, 32'hF0);

`ifdef SPI_READBACK_EN
      frame(32'h8433, 16);
      check("rb_wr4", {24'd0, r4}, 32'h33);
      frame(32'h0400, 16);
      check("rb_rd4", {24'd0, rx_word[7:0]}, 32'h33);
      check("rb_hdr", {24'd0, rx_word[15:8]}, 32'h00);
      check("rb_nocommit", {24'd0, r4}, 32'h33);
      frame(32'h0600, 16);
      check("rb_rd6", {24'd0, rx_word[7:0]}, 32'h00);
      check("rb_idle_cipo", {31'd0, cipo}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
